// File: rtl/f2i_pkg.sv
// Shared definitions for the float-to-int conversion slice: IEEE-754 constants,
// the response type and the single-cycle conversion function.
package f2i_pkg;

    localparam logic [7:0]  F32_EXP_BIAS = 8'd127;
    localparam logic [7:0]  F32_EXP_NAN  = 8'd255;
    localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN    = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
    } f2i_rsp_t;

    function automatic f2i_rsp_t f2i_convert(input logic [31:0] a);
        f2i_rsp_t   r;
        logic [7:0] e;
        logic [31:0] mag;
        r   = '0;
        e   = a[30:23] - F32_EXP_BIAS;
        mag = {8'd0, 1'b1, a[22:0]};
        if (a[30:23] < F32_EXP_BIAS) begin
            r = '0;
        end else if (a[30:23] == F32_EXP_NAN && a[22:0] != '0) begin
            r = '{INT32_MAX, 1'b1};
        end else if (e >= 8'd31) begin
            // -2^31 is the only exactly representable value in this range
            if (a[31] && e == 8'd31 && a[22:0] == '0)
                r = '{INT32_MIN, 1'b0};
            else
                r = '{(a[31] ? INT32_MIN : INT32_MAX), 1'b1};
        end else begin
            if (e >= 8'd23)
                mag = mag << (e - 8'd23);
            else
                mag = mag >> (8'd23 - e);
            r.data = a[31] ? (~mag + 32'd1) : mag;
            r.ovf  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/f2i_pipe_core.sv
// LAT-stage float-to-int converter; conversion happens entering stage 0, the
// remaining stages only delay the result together with its valid/id sideband.
module f2i_pipe_core
    import f2i_pkg::*;
#(
    parameter int LAT  = 2,
    parameter int ID_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    input  logic [31:0]              in_data_i,
    input  logic [ID_W-1:0]          in_id_i,
    output logic                     out_valid_o,
    output f2i_rsp_t                 out_rsp_o,
    output logic [ID_W-1:0]          out_id_o,
    output logic [$clog2(LAT+1)-1:0] inflight_o
);

    localparam int CNT_W = $clog2(LAT+1);

    logic [LAT-1:0]  vld_q;
    f2i_rsp_t        rsp_q [LAT];
    logic [ID_W-1:0] id_q  [LAT];
    f2i_rsp_t        rsp0_d;

    assign rsp0_d = f2i_convert(in_data_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                rsp_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else begin
            vld_q[0] <= in_valid_i;
            rsp_q[0] <= rsp0_d;
            id_q[0]  <= in_id_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                rsp_q[i] <= rsp_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    always_comb begin
        inflight_o = '0;
        for (int i = 0; i < LAT; i++)
            inflight_o = inflight_o + CNT_W'(vld_q[i]);
    end

    assign out_valid_o = vld_q[LAT-1];
    assign out_rsp_o   = rsp_q[LAT-1];
    assign out_id_o    = id_q[LAT-1];

endmodule

// File: rtl/f2i_shared_arbiter.sv
// Round-robin front end sharing one f2i pipeline among N_REQ requesters, with a
// credit-guarded show-ahead output FIFO so backpressure can never lose a result.
module f2i_shared_arbiter
    import f2i_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [32*N_REQ-1:0]      req_data_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [31:0]              rsp_data_o,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic                     rsp_ovf_o
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(LAT+1);

    typedef struct packed {
        f2i_rsp_t        rsp;
        logic [ID_W-1:0] id;
    } fifo_ent_t;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  gidx;
    logic             found, can_issue, issue;
    int               scan_idx;

    logic             pipe_vld;
    f2i_rsp_t         pipe_rsp;
    logic [ID_W-1:0]  pipe_id;
    logic [CNT_W-1:0] inflight;

    fifo_ent_t        mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             push, pop;
    fifo_ent_t        head;

    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        scan_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req_valid_i[scan_idx]) begin
                found = 1'b1;
                gidx  = ID_W'(scan_idx);
            end
        end
    end

    // Results already in flight each own a FIFO slot, so a push can never overflow
    assign can_issue = (32'(cnt_q) + 32'(inflight)) < FIFO_DEPTH;
    assign issue     = found & can_issue & ~rst;

    always_comb begin
        req_ready_o = '0;
        if (issue)
            req_ready_o[gidx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue)
            rr_ptr_d = (gidx == ID_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

    f2i_pipe_core #(.LAT(LAT), .ID_W(ID_W)) u_core (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (issue),
        .in_data_i  (req_data_i[32*int'(gidx) +: 32]),
        .in_id_i    (gidx),
        .out_valid_o(pipe_vld),
        .out_rsp_o  (pipe_rsp),
        .out_id_o   (pipe_id),
        .inflight_o (inflight)
    );

    assign push = pipe_vld;
    assign pop  = rsp_valid_o & rsp_ready_i;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_q] <= '{pipe_rsp, pipe_id};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)
                wr_q <= (wr_q == AW'(FIFO_DEPTH-1)) ? '0 : wr_q + 1'b1;
            if (pop)
                rd_q <= (rd_q == AW'(FIFO_DEPTH-1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head        = mem[rd_q];
    assign rsp_valid_o = (cnt_q != '0);
    assign rsp_data_o  = rsp_valid_o ? head.rsp.data : '0;
    assign rsp_ovf_o   = rsp_valid_o ? head.rsp.ovf  : 1'b0;
    assign rsp_id_o    = rsp_valid_o ? head.id       : '0;

endmodule
